// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table checker: FSM state encodings and
// the golden truth table of the default 5-input circuit.
package truth_table_checker_pkg;

    // Sweep controller states; the encodings are fixed so other tools can decode them.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Golden table for V'W'Z' + WY'Z + VXZ; bit i is the expected output for vector i.
    localparam logic [31:0] EXPECT_DEFAULT = 32'hA2A02255;

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Settle timer: counts enabled clock edges and flags the last settle cycle,
// i.e. expired is high while the count equals term_cnt-1.
module settle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] term_cnt,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    // Edge counter; clr has priority so every settle window starts from zero.
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign expired = (r_count == (term_cnt - WIDTH'(1)));

endmodule

// File: rtl/truth_table_checker.sv
// Truth-table checker: sweeps every input vector of an N_IN-input function
// block in ascending order, waits SETTLE cycles per vector, samples the
// block's output against the golden table and records mismatch statistics.
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int                  N_IN   = 5,
    parameter logic [2**N_IN-1:0]  EXPECT = EXPECT_DEFAULT,
    parameter int                  SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dut_in,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            first_fail_vld,
    output logic [N_IN-1:0] first_fail_idx
);

    state_t          r_state;
    state_t          w_next_state;
    logic [N_IN-1:0] r_vec_out;
    logic [N_IN:0]   r_err_cnt;
    logic            r_first_fail_vld;
    logic [N_IN-1:0] r_first_fail_idx;

    logic            w_settled;
    logic            w_accept_start;
    logic            w_mismatch;
    logic            w_last_vec;

    // Only the SETTLE state runs the timer; any other state holds it at zero,
    // which also covers the re-entry into SETTLE for the next vector.
    settle_timer #(
        .WIDTH (4)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (r_state != ST_SETTLE),
        .en       (r_state == ST_SETTLE),
        .term_cnt (4'(SETTLE)),
        .expired  (w_settled)
    );

    assign w_accept_start = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_mismatch     = (dut_in != EXPECT[r_vec_out]);
    assign w_last_vec     = &r_vec_out;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start is only looked at when no sweep is running.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:   if (start) w_next_state = ST_SETTLE;
            ST_SETTLE: if (w_settled) w_next_state = ST_SAMPLE;
            ST_SAMPLE: w_next_state = w_last_vec ? ST_DONE : ST_SETTLE;
            ST_DONE:   if (start) w_next_state = ST_SETTLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Vector counter, error counter and first-fail capture; the last sample's
    // result lands on the same edge that enters DONE, so results are final then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec_out        <= '0;
            r_err_cnt        <= '0;
            r_first_fail_vld <= 1'b0;
            r_first_fail_idx <= '0;
        end else if (w_accept_start) begin
            r_vec_out        <= '0;
            r_err_cnt        <= '0;
            r_first_fail_vld <= 1'b0;
            r_first_fail_idx <= '0;
        end else if (r_state == ST_SAMPLE) begin
            if (w_mismatch) begin
                // At most one increment per vector, so 2^N_IN is the ceiling.
                r_err_cnt <= r_err_cnt + (N_IN+1)'(1);
                if (!r_first_fail_vld) begin
                    r_first_fail_vld <= 1'b1;
                    r_first_fail_idx <= r_vec_out;
                end
            end
            if (!w_last_vec) begin
                r_vec_out <= r_vec_out + N_IN'(1);
            end
        end
    end

    assign vec_out        = r_vec_out;
    assign busy           = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign done           = (r_state == ST_DONE);
    assign pass           = done && (r_err_cnt == '0);
    assign err_cnt        = r_err_cnt;
    assign first_fail_vld = r_first_fail_vld;
    assign first_fail_idx = r_first_fail_idx;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: a small behavioural model of the
// 5-input circuit sits on dut_in and the checker's results are compared
// against hand-computed values for each scenario.
module tb_truth_table_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic       dut_in;
    logic [4:0] vec_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] err_cnt;
    logic       first_fail_vld;
    logic [4:0] first_fail_idx;

    int n_tests = 0;
    int n_fail  = 0;

    // 0 = golden, 1 = tied 0, 2 = tied 1, 3 = golden inverted at vector 13
    int mode = 0;

    truth_table_checker u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .dut_in         (dut_in),
        .vec_out        (vec_out),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_fail_vld (first_fail_vld),
        .first_fail_idx (first_fail_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Circuit under check: V'W'Z' + WY'Z + VXZ with V=bit4 ... Z=bit0.
    function automatic logic golden(input logic [4:0] v);
        logic vv, ww, xx, yy, zz;
        {vv, ww, xx, yy, zz} = v;
        return (~vv & ~ww & ~zz) | (ww & ~yy & zz) | (vv & xx & zz);
    endfunction

    always_comb begin
        case (mode)
            1:       dut_in = 1'b0;
            2:       dut_in = 1'b1;
            3:       dut_in = golden(vec_out) ^ (vec_out == 5'd13);
            default: dut_in = golden(vec_out);
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse (or hold) start, then verify busy through the sweep and done at +96.
    task automatic sweep(input string tag, input bit hold);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        check({tag, "_busy_k"}, busy, 1);
        check({tag, "_done_k"}, done, 0);
        check({tag, "_vec_k"}, vec_out, 0);
        check({tag, "_err_k"}, err_cnt, 0);
        check({tag, "_ffv_k"}, first_fail_vld, 0);
        repeat (95) @(posedge clk);
        #1;
        check({tag, "_busy_k95"}, busy, 1);
        check({tag, "_done_k95"}, done, 0);
        @(posedge clk);
        #1;
        check({tag, "_done_k96"}, done, 1);
        check({tag, "_busy_k96"}, busy, 0);
        check({tag, "_vec_k96"}, vec_out, 31);
    endtask

    task automatic results(input string tag, input int exp_err, input bit exp_ffv,
                           input int exp_idx);
        check({tag, "_err"}, err_cnt, exp_err);
        check({tag, "_pass"}, pass, (exp_err == 0));
        check({tag, "_ffv"}, first_fail_vld, exp_ffv);
        check({tag, "_ffidx"}, first_fail_idx, exp_idx);
    endtask

    initial begin
        bit found;
        rst   = 1'b1;
        start = 1'b0;
        #12;
        check("rst_vec", vec_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_cnt, 0);
        check("rst_ffv", first_fail_vld, 0);
        check("rst_ffidx", first_fail_idx, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: golden circuit
        mode = 0;
        sweep("golden", 1'b0);
        results("golden", 0, 1'b0, 0);

        // 2: tied low -> misses all 11 ones, first at vector 0
        mode = 1;
        sweep("tie0", 1'b0);
        results("tie0", 11, 1'b1, 0);
        repeat (5) @(posedge clk);
        #1;
        check("tie0_hold_done", done, 1);
        check("tie0_hold_err", err_cnt, 11);

        // 3: tied high -> 21 zeros wrong, first at vector 1
        mode = 2;
        sweep("tie1", 1'b0);
        results("tie1", 21, 1'b1, 1);

        // 4: single fault at vector 13
        mode = 3;
        sweep("inv13", 1'b0);
        results("inv13", 1, 1'b1, 13);

        // 5: reset mid-sweep at vector 10
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (vec_out == 5'd10) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("midrst_reach10", found, 1);
        check("midrst_err_before", err_cnt, 5);
        rst = 1'b1;
        #1;
        check("midrst_vec", vec_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err_cnt, 0);
        check("midrst_ffv", first_fail_vld, 0);
        check("midrst_ffidx", first_fail_idx, 0);
        @(negedge clk);
        rst  = 1'b0;
        mode = 0;
        sweep("after_rst", 1'b0);
        results("after_rst", 0, 1'b0, 0);

        // 6: start held high through two sweeps
        mode = 1;
        sweep("hold1", 1'b1);
        results("hold1", 11, 1'b1, 0);
        @(posedge clk);
        #1;
        check("hold_restart_done", done, 0);
        check("hold_restart_busy", busy, 1);
        check("hold_restart_vec", vec_out, 0);
        check("hold_restart_err", err_cnt, 0);
        repeat (95) @(posedge clk);
        #1;
        check("hold2_busy_k95", busy, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hold2_done", done, 1);
        results("hold2", 11, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
